// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the datapath: one micro-step per clock.
// It drives every datapath strobe for fetch and for the supported instructions.
module control_sequencer (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  output logic        pc_out,
  output logic        zlo_out,
  output logic        mdr_out,
  output logic        ba_out,
  output logic        r_out,
  output logic        c_sign_extended_out,
  output logic        mar_enable,
  output logic        mdr_enable,
  output logic        ir_enable,
  output logic        y_enable,
  output logic        z_enable,
  output logic        pc_enable,
  output logic        r_in,
  output logic        r15_enable,
  output logic        gra,
  output logic        grb,
  output logic        grc,
  output logic        read,
  output logic        ram_write,
  output logic        pc_increment,
  output logic [4:0]  alu_op,
  output logic        run,
  output logic [3:0]  state
);

  // Fetch steps T0..T7 occupy codes 1..8, so the debug code is the step number plus one.
  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_HALT = 4'd9
  } state_e;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_e     state_q, state_d;
  logic [4:0] opcode_q;
  logic [4:0] op_ir;

  logic       op_alu, op_imm, op_mem, op_ldi, op_st, op_jal, op_jr;
  logic       has_exec;
  logic       unused_ir_bits;

  assign op_ir          = ir[31:27];
  assign unused_ir_bits = ^ir[26:0];

  // Instructions that continue past T2; everything else (nop, undefined) refetches.
  always_comb begin
    unique case (op_ir)
      OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_ADDI, OP_ANDI, OP_ORI, OP_JR, OP_JAL: has_exec = 1'b1;
      default:                                 has_exec = 1'b0;
    endcase
  end

  assign op_alu = (opcode_q == OP_ADD) || (opcode_q == OP_SUB) ||
                  (opcode_q == OP_AND) || (opcode_q == OP_OR);
  assign op_imm = (opcode_q == OP_ADDI) || (opcode_q == OP_ANDI) || (opcode_q == OP_ORI);
  assign op_st  = (opcode_q == OP_ST);
  assign op_mem = (opcode_q == OP_LD) || op_st;
  assign op_ldi = (opcode_q == OP_LDI);
  assign op_jal = (opcode_q == OP_JAL);
  assign op_jr  = (opcode_q == OP_JR);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = S_T2;
      S_T2: begin
        if (op_ir == OP_HALT) state_d = S_HALT;
        else if (has_exec)    state_d = S_T3;
        else                  state_d = S_T0;
      end
      S_T3:   state_d = op_jr  ? S_T0 : S_T4;
      S_T4:   state_d = op_jal ? S_T0 : S_T5;
      S_T5:   state_d = op_mem ? S_T6 : S_T0;
      S_T6:   state_d = S_T7;
      S_T7:   state_d = S_T0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= S_IDLE;
      opcode_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == S_T3) opcode_q <= op_ir;
    end
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    pc_out              = 1'b0;
    zlo_out             = 1'b0;
    mdr_out             = 1'b0;
    ba_out              = 1'b0;
    r_out               = 1'b0;
    c_sign_extended_out = 1'b0;
    mar_enable          = 1'b0;
    mdr_enable          = 1'b0;
    ir_enable           = 1'b0;
    y_enable            = 1'b0;
    z_enable            = 1'b0;
    pc_enable           = 1'b0;
    r_in                = 1'b0;
    r15_enable          = 1'b0;
    gra                 = 1'b0;
    grb                 = 1'b0;
    grc                 = 1'b0;
    read                = 1'b0;
    ram_write           = 1'b0;
    pc_increment        = 1'b0;
    alu_op              = OP_ADD;
    case (state_q)
      S_T0: begin
        pc_out       = 1'b1;
        mar_enable   = 1'b1;
        pc_increment = 1'b1;
        z_enable     = 1'b1;
      end
      S_T1: begin
        zlo_out    = 1'b1;
        pc_enable  = 1'b1;
        read       = 1'b1;
        mdr_enable = 1'b1;
      end
      S_T2: begin
        mdr_out   = 1'b1;
        ir_enable = 1'b1;
      end
      S_T3: begin
        if (op_jal) begin
          pc_out     = 1'b1;
          r15_enable = 1'b1;
        end else if (op_jr) begin
          gra       = 1'b1;
          r_out     = 1'b1;
          pc_enable = 1'b1;
        end else begin
          grb      = 1'b1;
          y_enable = 1'b1;
          if (op_ldi || op_mem) ba_out = 1'b1;
          else                  r_out  = 1'b1;
        end
      end
      S_T4: begin
        if (op_jal) begin
          gra       = 1'b1;
          r_out     = 1'b1;
          pc_enable = 1'b1;
        end else if (op_alu) begin
          grc      = 1'b1;
          r_out    = 1'b1;
          z_enable = 1'b1;
          alu_op   = opcode_q;
        end else begin
          c_sign_extended_out = 1'b1;
          z_enable            = 1'b1;
          if (op_imm) alu_op = opcode_q;
        end
      end
      S_T5: begin
        zlo_out = 1'b1;
        if (op_mem) begin
          mar_enable = 1'b1;
        end else begin
          gra  = 1'b1;
          r_in = 1'b1;
        end
      end
      S_T6: begin
        mdr_enable = 1'b1;
        if (op_st) begin
          gra   = 1'b1;
          r_out = 1'b1;
        end else begin
          read = 1'b1;
        end
      end
      S_T7: begin
        if (op_st) begin
          ram_write = 1'b1;
        end else begin
          mdr_out = 1'b1;
          gra     = 1'b1;
          r_in    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign run   = (state_q != S_IDLE) && (state_q != S_HALT);
  assign state = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a table-driven instruction model checked every cycle,
// plus directed instructions with hand-computed step contents and cycle counts.
module tb_control_sequencer;

  logic        clk;
  logic        clr;
  logic [31:0] ir;
  logic pc_out, zlo_out, mdr_out, ba_out, r_out, c_sign_extended_out;
  logic mar_enable, mdr_enable, ir_enable, y_enable, z_enable, pc_enable, r_in, r15_enable;
  logic gra, grb, grc, read, ram_write, pc_increment, run;
  logic [4:0] alu_op;
  logic [3:0] state;

  control_sequencer dut (
    .clk(clk), .clr(clr), .ir(ir),
    .pc_out(pc_out), .zlo_out(zlo_out), .mdr_out(mdr_out), .ba_out(ba_out),
    .r_out(r_out), .c_sign_extended_out(c_sign_extended_out),
    .mar_enable(mar_enable), .mdr_enable(mdr_enable), .ir_enable(ir_enable),
    .y_enable(y_enable), .z_enable(z_enable), .pc_enable(pc_enable),
    .r_in(r_in), .r15_enable(r15_enable),
    .gra(gra), .grb(grb), .grc(grc),
    .read(read), .ram_write(ram_write), .pc_increment(pc_increment),
    .alu_op(alu_op), .run(run), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe vector bit positions, in the order of strobes() below.
  localparam logic [19:0] PCO   = 20'h80000, ZLO  = 20'h40000, MDRO = 20'h20000;
  localparam logic [19:0] BAO   = 20'h10000, ROUT = 20'h08000, CSX  = 20'h04000;
  localparam logic [19:0] MARE  = 20'h02000, MDRE = 20'h01000, IRE  = 20'h00800;
  localparam logic [19:0] YEN   = 20'h00400, ZEN  = 20'h00200, PCE  = 20'h00100;
  localparam logic [19:0] RIN   = 20'h00080, R15E = 20'h00040, GRA  = 20'h00020;
  localparam logic [19:0] GRB   = 20'h00010, GRC  = 20'h00008, READ = 20'h00004;
  localparam logic [19:0] RAMW  = 20'h00002, PCINC = 20'h00001;

  localparam logic [3:0] ST_IDLE = 4'd0, ST_T0 = 4'd1, ST_T3 = 4'd4, ST_T4 = 4'd5;
  localparam logic [3:0] ST_T5 = 4'd6, ST_T6 = 4'd7, ST_T7 = 4'd8, ST_HALT = 4'd9;

  typedef enum int {C_NOP, C_LDI, C_IMM, C_ALU, C_LD, C_ST, C_JAL, C_JR, C_HALT} cls_e;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [19:0] strobes();
    return {pc_out, zlo_out, mdr_out, ba_out, r_out, c_sign_extended_out,
            mar_enable, mdr_enable, ir_enable, y_enable, z_enable, pc_enable,
            r_in, r15_enable, gra, grb, grc, read, ram_write, pc_increment};
  endfunction

  function automatic cls_e classify(input logic [4:0] op);
    case (op)
      5'd1:               return C_LDI;
      5'd12, 5'd13, 5'd14: return C_IMM;
      5'd3, 5'd4, 5'd5, 5'd6: return C_ALU;
      5'd0:               return C_LD;
      5'd2:               return C_ST;
      5'd21:              return C_JAL;
      5'd20:              return C_JR;
      5'd27:              return C_HALT;
      default:            return C_NOP;
    endcase
  endfunction

  function automatic int cycles_of(input cls_e c);
    case (c)
      C_NOP:       return 3;
      C_JR:        return 4;
      C_JAL:       return 5;
      C_LD, C_ST:  return 8;
      default:     return 6;
    endcase
  endfunction

  // Per-class micro-step contents, indexed [class][step].
  logic [19:0] mask_tab [0:8][0:7];

  initial begin
    for (int c = 0; c < 9; c++) begin
      for (int s = 0; s < 8; s++) mask_tab[c][s] = '0;
      mask_tab[c][0] = PCO | MARE | PCINC | ZEN;
      mask_tab[c][1] = ZLO | PCE | READ | MDRE;
      mask_tab[c][2] = MDRO | IRE;
    end
    mask_tab[C_LDI][3] = GRB | BAO | YEN;
    mask_tab[C_LDI][4] = CSX | ZEN;
    mask_tab[C_LDI][5] = ZLO | GRA | RIN;
    mask_tab[C_IMM][3] = GRB | ROUT | YEN;
    mask_tab[C_IMM][4] = CSX | ZEN;
    mask_tab[C_IMM][5] = ZLO | GRA | RIN;
    mask_tab[C_ALU][3] = GRB | ROUT | YEN;
    mask_tab[C_ALU][4] = GRC | ROUT | ZEN;
    mask_tab[C_ALU][5] = ZLO | GRA | RIN;
    for (int c = C_LD; c <= C_ST; c++) begin
      mask_tab[c][3] = GRB | BAO | YEN;
      mask_tab[c][4] = CSX | ZEN;
      mask_tab[c][5] = ZLO | MARE;
    end
    mask_tab[C_LD][6]  = READ | MDRE;
    mask_tab[C_LD][7]  = MDRO | GRA | RIN;
    mask_tab[C_ST][6]  = GRA | ROUT | MDRE;
    mask_tab[C_ST][7]  = RAMW;
    mask_tab[C_JAL][3] = PCO | R15E;
    mask_tab[C_JAL][4] = GRA | ROUT | PCE;
    mask_tab[C_JR][3]  = GRA | ROUT | PCE;
  end

  // Model: m_step = -1 idle, 0..7 step within instruction, 8 halted.
  int         m_step = -1;
  cls_e       m_cls  = C_LD;
  logic [4:0] m_op   = '0;

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      m_step <= -1;
      m_op   <= '0;
    end else if (m_step == -1) begin
      m_step <= 0;
    end else if (m_step == 8) begin
      m_step <= 8;
    end else if (m_step == 2) begin
      if (classify(ir[31:27]) == C_HALT)          m_step <= 8;
      else if (cycles_of(classify(ir[31:27])) == 3) m_step <= 0;
      else begin
        m_step <= 3;
        m_cls  <= classify(ir[31:27]);
        m_op   <= ir[31:27];
      end
    end else if (m_step == cycles_of(m_cls) - 1) begin
      m_step <= 0;
    end else begin
      m_step <= m_step + 1;
    end
  end

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [3:0]  e_state;
      logic [19:0] e_strb;
      logic [4:0]  e_alu;
      logic        e_run;
      e_alu = 5'b00011;
      if (m_step < 0 || m_step == 8) begin
        e_state = (m_step < 0) ? 4'd0 : 4'd9;
        e_strb  = '0;
        e_run   = 1'b0;
      end else begin
        e_state = 4'(m_step + 1);
        e_strb  = mask_tab[m_cls][m_step];
        e_run   = 1'b1;
        if (m_step == 4 && (m_cls == C_ALU || m_cls == C_IMM)) e_alu = m_op;
      end
      check("cyc_state", state, e_state);
      check("cyc_strobes", strobes(), e_strb);
      check("cyc_alu_op", alu_op, e_alu);
      check("cyc_run", run, e_run);
      check("cyc_one_bus_driver",
            ($countones({pc_out, zlo_out, mdr_out, r_out, c_sign_extended_out}) <= 1), 1);
    end
  end

  logic [19:0] snap_strb [0:15];
  logic [4:0]  snap_alu  [0:15];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Starting in T0, present one instruction and count cycles until the next T0 (or HALT).
  task automatic exec(input logic [31:0] ir_val, input bit scramble, output int cycles);
    ir     = ir_val;
    cycles = 0;
    do begin
      tick();
      cycles++;
      snap_strb[state] = strobes();
      snap_alu[state]  = alu_op;
      if (scramble && state == ST_T3) ir = 32'h0;
    end while (state != ST_T0 && state != ST_HALT && cycles < 20);
    if (cycles >= 20) check("exec_timeout", state, ST_T0);
  endtask

  int n;

  initial begin
    clr = 1'b0;
    ir  = 32'h0;
    repeat (2) @(posedge clk);
    #2;
    check("reset_state", state, ST_IDLE);
    check("reset_strobes", strobes(), 20'h0);
    check("reset_alu_op", alu_op, 5'b00011);
    check("reset_run", run, 1'b0);
    clr    = 1'b1;
    cmp_en = 1'b1;
    tick();
    check("first_t0_state", state, ST_T0);
    check("first_t0_strobes", strobes(), PCO | MARE | PCINC | ZEN);

    exec(32'h09000005, 1'b0, n);
    check("ldi_cycles", n, 6);
    check("ldi_t5", snap_strb[ST_T5], ZLO | GRA | RIN);

    exec(32'h18918000, 1'b1, n);
    check("add_cycles", n, 6);
    check("add_t4", snap_strb[ST_T4], GRC | ROUT | ZEN);
    check("add_t4_alu", snap_alu[ST_T4], 5'b00011);

    exec(32'h20000000, 1'b0, n);
    check("sub_t4_alu", snap_alu[ST_T4], 5'b00100);

    exec(32'h60000000, 1'b1, n);
    check("addi_cycles", n, 6);
    check("addi_t3", snap_strb[ST_T3], GRB | ROUT | YEN);
    check("addi_t4_alu", snap_alu[ST_T4], 5'b01100);

    exec(32'h10000000, 1'b0, n);
    check("st_cycles", n, 8);
    check("st_t7", snap_strb[ST_T7], RAMW);
    check("st_t6", snap_strb[ST_T6], GRA | ROUT | MDRE);

    exec(32'h00000000, 1'b0, n);
    check("ld_cycles", n, 8);
    check("ld_t6", snap_strb[ST_T6], READ | MDRE);

    exec(32'hAA000000, 1'b0, n);
    check("jal_cycles", n, 5);
    check("jal_t3", snap_strb[ST_T3], PCO | R15E);
    check("jal_t4", snap_strb[ST_T4], GRA | ROUT | PCE);

    exec(32'hA0000000, 1'b0, n);
    check("jr_cycles", n, 4);
    exec(32'hD0000000, 1'b0, n);
    check("nop_cycles", n, 3);
    exec(32'hF8000000, 1'b0, n);
    check("undef_cycles", n, 3);

    // Abort an add in T4 with reset.
    ir = 32'h18918000;
    n  = 0;
    do begin
      tick();
      n++;
    end while (state != ST_T4 && n < 20);
    check("abort_reached_t4", state, ST_T4);
    clr = 1'b0;
    #1;
    check("abort_state", state, ST_IDLE);
    check("abort_strobes", strobes(), 20'h0);
    check("abort_alu_op", alu_op, 5'b00011);
    check("abort_run", run, 1'b0);
    tick();
    clr = 1'b1;
    tick();
    check("abort_restart_t0", state, ST_T0);

    exec(32'hD8000000, 1'b0, n);
    check("halt_cycles", n, 3);
    ir = 32'h09000005;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("halt_state", state, ST_HALT);
      check("halt_run", run, 1'b0);
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
